// File: rtl/ccx_chunk_unit.sv
// Chunk-serial CCX execution unit: streams two operands LSB chunk first, applies AND/OR/XOR/ADD
// per chunk and returns result chunks through a fixed-latency pipeline.
module ccx_chunk_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CHUNKSIZE = 4,
  parameter int unsigned RES_DLY   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [1:0]           sel_i,
  input  logic [CHUNKSIZE-1:0] rs_a_i,
  input  logic [CHUNKSIZE-1:0] rs_b_i,
  output logic [CHUNKSIZE-1:0] res_o,
  output logic                 res_vld_o,
  output logic                 resp_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned NCHUNK = XLEN / CHUNKSIZE;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {StIdle, StCollect} state_e;
  typedef enum logic [1:0] {FnAnd, FnOr, FnXor, FnAdd} fn_e;

  typedef struct packed {
    logic [CHUNKSIZE-1:0] res;
    logic                 vld;
    logic                 last;
  } stage_t;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  fn_e                 sel_q, sel_d;
  logic                carry_q, carry_d;
  logic                err_q, err_d;
  stage_t              pipe_q [RES_DLY];
  stage_t              stage_d;

  logic                proc;
  logic                last_chunk;
  fn_e                 fn;
  logic                cin;
  logic [CHUNKSIZE:0]  sum;
  logic [CHUNKSIZE-1:0] f_res;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    carry_d    = carry_q;
    err_d      = 1'b0;
    proc       = 1'b0;
    last_chunk = 1'b0;
    fn         = sel_q;
    cin        = carry_q;

    unique case (state_q)
      StIdle: begin
        // Chunk 0 is processed in the accept cycle with the live select and a clean carry.
        fn  = fn_e'(sel_i);
        cin = 1'b0;
        if (req_i) begin
          proc    = 1'b1;
          sel_d   = fn_e'(sel_i);
          carry_d = 1'b0;
          if (NCHUNK == 1) begin
            last_chunk = 1'b1;
          end else begin
            state_d = StCollect;
            cnt_d   = CntW'(1);
          end
        end
      end
      StCollect: begin
        proc  = 1'b1;
        err_d = req_i;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NCHUNK - 1)) begin
          last_chunk = 1'b1;
          state_d    = StIdle;
          cnt_d      = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    sum = {1'b0, rs_a_i} + {1'b0, rs_b_i} + {{CHUNKSIZE{1'b0}}, cin};

    case (fn)
      FnAnd:   f_res = rs_a_i & rs_b_i;
      FnOr:    f_res = rs_a_i | rs_b_i;
      FnXor:   f_res = rs_a_i ^ rs_b_i;
      default: f_res = sum[CHUNKSIZE-1:0];
    endcase

    if (proc && (fn == FnAdd)) begin
      carry_d = sum[CHUNKSIZE];
    end

    stage_d = proc ? '{res: f_res, vld: 1'b1, last: last_chunk} : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= FnAnd;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < RES_DLY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
      pipe_q[0] <= stage_d;
      for (int i = 1; i < RES_DLY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  stage_t out_stage;

  always_comb begin
    out_stage = pipe_q[RES_DLY-1];
    res_o     = out_stage.vld ? out_stage.res : '0;
    res_vld_o = out_stage.vld;
    resp_o    = out_stage.vld & out_stage.last;
    busy_o    = (state_q == StCollect);
    err_o     = err_q;
  end

endmodule
